// File: rtl/modn_cascade_counter.sv
// Cascadable modulo-N up/down counter stage with IDLE/RUN/PAUSE run control.
// Chain stages by feeding each stage's cout into the next stage's cin.
`timescale 1ns/1ps
module modn_cascade_counter #(
  parameter int unsigned MODULUS = 10,
  parameter int unsigned WIDTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_resume,
  input  logic             stop,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up_down,
  input  logic             cin,
  output logic [WIDTH-1:0] number,
  output logic             cout,
  output logic             running
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

  state_t           state;
  logic             count_en;
  logic             at_limit;
  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] load_sat;

  always_comb begin
    count_en   = (state == RUN) & cin & ~clear & ~load;
    at_limit   = up_down ? (number == MAX_VAL) : (number == '0);
    next_count = number;
    if (up_down)
      next_count = at_limit ? '0 : number + WIDTH'(1);
    else
      next_count = at_limit ? MAX_VAL : number - WIDTH'(1);
    // Out-of-range loads saturate so number never leaves 0..MODULUS-1.
    load_sat = ({1'b0, load_value} < MOD_EXT) ? load_value : MAX_VAL;
  end

  assign running = (state == RUN);
  assign cout    = count_en & at_limit;

  always_ff @(posedge clk) begin
    if (reset) begin
      number <= '0;
      state  <= IDLE;
    end else if (clear) begin
      number <= '0;
      state  <= IDLE;
    end else if (load) begin
      number <= load_sat;
    end else begin
      // Count decision uses the current state, so the stop cycle still counts.
      if (count_en)
        number <= next_count;
      case (state)
        IDLE:    if (start_resume && !stop) state <= RUN;
        RUN:     if (stop) state <= PAUSE;
        PAUSE:   if (start_resume && !stop) state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/modn_cascade_counter.md
MODN_CASCADE_COUNTER -- requirements
Module: modn_cascade_counter

Interface
REQ-001 SHALL provide parameter MODULUS, 10, count range 0..MODULUS-1 (legal 2..2^WIDTH).
REQ-002 SHALL provide parameter WIDTH, 4, bit width of count value.
REQ-003 SHALL provide port clk  in  1  single clock; all state updates on posedge clk.
REQ-004 SHALL provide port reset  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 SHALL provide port start_resume  in  1  level/pulse request to enter RUN.
REQ-006 SHALL provide port stop  in  1  request to leave RUN and enter PAUSE.
REQ-007 SHALL provide port clear  in  1  synchronous zero of count, returns FSM to IDLE.
REQ-008 SHALL provide port load  in  1  synchronous load of load_value.
REQ-009 SHALL provide port load_value  in  WIDTH  value written on load.
REQ-010 SHALL provide port up_down  in  1  1 = count up, 0 = count down.
REQ-011 SHALL provide port cin  in  1  count enable from lower stage; tie 1 for least significant stage.
REQ-012 SHALL provide port number  out  WIDTH  registered current count.
REQ-013 SHALL provide port cout  out  1  combinational carry/borrow to next stage.
REQ-014 SHALL provide port running  out  1  high when FSM is in RUN.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, PAUSE.
REQ-016 IDLE: start_resume=1 and stop=0 -> RUN; otherwise stay.
REQ-017 RUN: stop=1 -> PAUSE (stop wins over simultaneous start_resume); otherwise stay.
REQ-018 PAUSE: start_resume=1 and stop=0 -> RUN; otherwise stay; count held.
REQ-019 SHALL apply per-cycle priority reset > clear > load > count > hold.
REQ-020 clear: number <= 0, state <= IDLE, regardless of current state.
REQ-021 load: number <= load_value if load_value < MODULUS, else MODULUS-1 (saturate); state unchanged; load allowed in any state.
REQ-022 count occurs only when state==RUN and cin=1 and no clear/load; one step per qualifying cycle, zero-cycle decision latency (new number visible the cycle after the qualifying edge).
REQ-023 up count: MODULUS-1 wraps to 0; else +1.
REQ-024 down count: 0 wraps to MODULUS-1; else -1.
REQ-025 cout = running & cin & ~clear & ~load & (up_down ? number==MODULUS-1 : number==0); asserted only in the cycle that produces the wrap.
REQ-026 cout SHALL NOT assert in IDLE, PAUSE, or on the first cycle after reset.
REQ-027 number SHALL never hold a value >= MODULUS.
REQ-028 up_down change takes effect on the next counting edge; no glitch of number.
REQ-029 FSM transition and count evaluated from same-cycle state: the cycle stop is asserted in RUN still counts (state is RUN); counting resumes the cycle after RUN is re-entered.
REQ-030 Cascading: stage k cin = stage k-1 cout; chained stages SHALL form a correct multi-digit counter with no extra latency per stage.

Reset
REQ-031 reset=1 at posedge clk: number <= 0, state <= IDLE; running=0, cout=0 the following cycle.
REQ-032 reset overrides clear, load, start_resume, stop in the same cycle.
REQ-033 reset mid-RUN SHALL abort counting; no cout pulse generated by reset.
REQ-034 outputs undefined only before the first reset edge; bench applies reset >=1 cycle.

Verification
REQ-035 MODULUS=10, reset, start_resume pulse, cin=1, up: number 0,1..9,0; cout high exactly in cycle number==9; running=1.
REQ-036 MODULUS=10, down from load_value=3: number 3,2,1,0,9; cout high only when number==0.
REQ-037 RUN at number=5, stop and start_resume same cycle -> PAUSE, number holds 6 (stop cycle counted); later start_resume -> counting resumes from 6.
REQ-038 load_value=12 with MODULUS=10 -> number=9; load and clear same cycle -> number=0, state IDLE.
REQ-039 two cascaded MODULUS=10 stages, cin0=1: count 00..99 -> 00; upper stage increments only on lower 9->0; upper cout high at 99.
REQ-040 MODULUS=6, reset asserted while number=4 in RUN -> number=0, running=0, cout=0 next cycle.
